// File: rtl/usb_tx_pkt_seq.sv
// USB transmit packet sequencer: emits SYNC, PID and body one bit per cycle, steering the
// external crc block through the body/CRC phases and finishing with EOP.
module usb_tx_pkt_seq #(
    parameter int unsigned EOP_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] pkt_kind,
    input  logic [3:0] pid,
    input  logic [6:0] addr,
    input  logic [3:0] endp,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       byte_last,
    output logic       byte_ready,
    input  logic       stall,
    input  logic       crc_sending,
    output logic       crc_inb,
    output logic       crc_recving,
    output logic       crc_start,
    output logic       crc_pkttype,
    output logic       crc_clear,
    output logic       raw_bit,
    output logic       raw_valid,
    output logic       eop,
    output logic       busy,
    output logic       done,
    output logic       err_underrun
);

    localparam logic [1:0] KindToken = 2'd0;
    localparam logic [1:0] KindData  = 2'd1;
    localparam logic [1:0] KindHs    = 2'd2;

    typedef enum logic [2:0] {StIdle, StSync, StPid, StBody, StCrcWait, StAbort, StEop} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [10:0] shreg_q, shreg_d;
    logic        last_q, last_d;
    logic [1:0]  kind_q, kind_d;
    logic [3:0]  pid_q, pid_d;
    logic [6:0]  addr_q, addr_d;
    logic [3:0]  endp_q, endp_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shreg_q <= '0;
            last_q  <= 1'b0;
            kind_q  <= '0;
            pid_q   <= '0;
            addr_q  <= '0;
            endp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            last_q  <= last_d;
            kind_q  <= kind_d;
            pid_q   <= pid_d;
            addr_q  <= addr_d;
            endp_q  <= endp_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        last_d       = last_q;
        kind_d       = kind_q;
        pid_d        = pid_q;
        addr_d       = addr_q;
        endp_d       = endp_q;
        byte_ready   = 1'b0;
        crc_inb      = 1'b0;
        crc_recving  = 1'b0;
        crc_start    = 1'b0;
        crc_pkttype  = 1'b0;
        crc_clear    = 1'b0;
        raw_bit      = 1'b0;
        raw_valid    = 1'b0;
        eop          = 1'b0;
        done         = 1'b0;
        err_underrun = 1'b0;
        busy         = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (start && pkt_kind != 2'd3) begin
                    state_d = StSync;
                    cnt_d   = '0;
                    kind_d  = pkt_kind;
                    pid_d   = pid;
                    addr_d  = addr;
                    endp_d  = endp;
                end
            end
            StSync: begin
                raw_valid = 1'b1;
                raw_bit   = (cnt_q == 8'd7);
                if (!stall) begin
                    if (cnt_q == 8'd7) begin
                        state_d = StPid;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StPid: begin
                raw_valid = 1'b1;
                raw_bit   = cnt_q[2] ? ~pid_q[cnt_q[1:0]] : pid_q[cnt_q[1:0]];
                if (cnt_q == 8'd7 && kind_q != KindHs) begin
                    crc_start   = 1'b1;
                    crc_pkttype = (kind_q == KindData);
                end
                if (!stall) begin
                    if (cnt_q == 8'd7) begin
                        cnt_d = '0;
                        if (kind_q == KindToken) begin
                            shreg_d = {endp_q, addr_q};
                            state_d = StBody;
                        end else if (kind_q == KindData) begin
                            byte_ready = 1'b1;
                            if (byte_valid) begin
                                shreg_d = {3'b000, byte_in};
                                last_d  = byte_last;
                                state_d = StBody;
                            end else begin
                                err_underrun = 1'b1;
                                state_d      = StAbort;
                            end
                        end else begin
                            state_d = StEop;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StBody: begin
                crc_recving = 1'b1;
                crc_inb     = shreg_q[0];
                if (!stall) begin
                    shreg_d = shreg_q >> 1;
                    cnt_d   = cnt_q + 8'd1;
                    if (kind_q == KindToken) begin
                        if (cnt_q == 8'd10) state_d = StCrcWait;
                    end else if (cnt_q == 8'd7) begin
                        cnt_d = '0;
                        if (last_q) begin
                            state_d = StCrcWait;
                        end else begin
                            byte_ready = 1'b1;
                            if (byte_valid) begin
                                shreg_d = {3'b000, byte_in};
                                last_d  = byte_last;
                            end else begin
                                err_underrun = 1'b1;
                                state_d      = StAbort;
                            end
                        end
                    end
                end
            end
            // crc block owns the line here; stall is handled inside it
            StCrcWait: begin
                if (!crc_sending) begin
                    state_d = StEop;
                    cnt_d   = '0;
                end
            end
            StAbort: begin
                crc_clear = 1'b1;
                state_d   = StEop;
                cnt_d     = '0;
            end
            StEop: begin
                eop = 1'b1;
                if (cnt_q == 8'(EOP_LEN - 1)) done = !stall;
                if (!stall) begin
                    if (cnt_q == 8'(EOP_LEN - 1)) state_d = StIdle;
                    else cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_usb_tx_pkt_seq.sv
// Randomized self-checking bench for usb_tx_pkt_seq against a slot-list reference model.
module tb_usb_tx_pkt_seq;

    localparam int unsigned EOP_LEN = 3;

    // expected-output vector bits
    localparam logic [11:0] B_BUSY = 12'h800, B_RV = 12'h400, B_RB = 12'h200, B_REC = 12'h100;
    localparam logic [11:0] B_INB = 12'h080, B_CST = 12'h040, B_PT = 12'h020, B_BR = 12'h010;
    localparam logic [11:0] B_EOP = 12'h008, B_DONE = 12'h004, B_CLR = 12'h002, B_UND = 12'h001;
    localparam logic [11:0] GATED = B_BR | B_DONE | B_UND;

    logic clk = 1'b0, rst = 1'b1;
    logic start = 1'b0, byte_valid = 1'b0, byte_last = 1'b0, stall = 1'b0, crc_sending = 1'b0;
    logic [1:0] pkt_kind = '0;
    logic [3:0] pid = '0, endp = '0;
    logic [6:0] addr = '0;
    logic [7:0] byte_in = '0;
    logic byte_ready, crc_inb, crc_recving, crc_start, crc_pkttype, crc_clear;
    logic raw_bit, raw_valid, eop, busy, done, err_underrun;

    always #5 clk = ~clk;

    usb_tx_pkt_seq #(.EOP_LEN(EOP_LEN)) dut (
        .clk(clk), .rst(rst), .start(start), .pkt_kind(pkt_kind), .pid(pid), .addr(addr),
        .endp(endp), .byte_in(byte_in), .byte_valid(byte_valid), .byte_last(byte_last),
        .byte_ready(byte_ready), .stall(stall), .crc_sending(crc_sending), .crc_inb(crc_inb),
        .crc_recving(crc_recving), .crc_start(crc_start), .crc_pkttype(crc_pkttype),
        .crc_clear(crc_clear), .raw_bit(raw_bit), .raw_valid(raw_valid), .eop(eop),
        .busy(busy), .done(done), .err_underrun(err_underrun)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [11:0] outs();
        return {busy, raw_valid, raw_bit, crc_recving, crc_inb, crc_start, crc_pkttype,
                byte_ready, eop, done, crc_clear, err_underrun};
    endfunction

    typedef struct {
        logic [11:0] out;
        logic        sending;
        logic        stl;
        int          bidx;
    } cyc_t;

    cyc_t       sched[$];
    int         stall_plan[int];
    int         slot_no;
    logic [7:0] pbytes[8];
    int         pn, pund;

    // One line slot; a planned stall repeats it frozen, minus the handshake/pulse outputs.
    task automatic push_slot(input logic [11:0] o, input logic snd, input bit stallable,
                             input int bidx);
        cyc_t c;
        c.sending = snd;
        c.bidx    = bidx;
        if (stallable && stall_plan.exists(slot_no)) begin
            for (int k = 0; k < stall_plan[slot_no]; k++) begin
                c.out = o & ~GATED;
                c.stl = 1'b1;
                sched.push_back(c);
            end
        end
        c.out = o;
        c.stl = 1'b0;
        sched.push_back(c);
        slot_no++;
    endtask

    task automatic build(input logic [1:0] kind, input logic [3:0] p, input logic [6:0] a,
                         input logic [3:0] e);
        logic [11:0] o;
        logic [10:0] tbits;
        logic        bitv;
        bit          aborted;
        int          cur_b, crc_len;
        sched.delete();
        slot_no = 0;
        aborted = 0;
        cur_b   = 0;
        crc_len = (kind == 2'd1) ? 16 : 5;
        for (int i = 0; i < 8; i++) push_slot(B_BUSY | B_RV | ((i == 7) ? B_RB : 12'h0), 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            bitv = (i < 4) ? p[i] : ~p[i-4];
            o = B_BUSY | B_RV | (bitv ? B_RB : 12'h0);
            if (i == 7 && kind != 2'd2) o |= B_CST;
            if (i == 7 && kind == 2'd1) begin
                o |= B_PT | B_BR;
                if (pund == 0) begin
                    o |= B_UND;
                    aborted = 1;
                end
            end
            push_slot(o, 0, 1, 0);
        end
        if (kind == 2'd0) begin
            tbits = {e, a};
            for (int i = 0; i < 11; i++) push_slot(B_BUSY | B_REC | (tbits[i] ? B_INB : 12'h0),
                                                   0, 1, 0);
        end else if (kind == 2'd1 && !aborted) begin
            for (int j = 0; j < pn && !aborted; j++) begin
                cur_b = j + 1;
                for (int b = 0; b < 8; b++) begin
                    o = B_BUSY | B_REC | (pbytes[j][b] ? B_INB : 12'h0);
                    if (b == 7 && j < pn - 1) begin
                        o |= B_BR;
                        if (j + 1 == pund) begin
                            o |= B_UND;
                            aborted = 1;
                        end
                    end
                    push_slot(o, 0, 1, cur_b);
                end
            end
        end
        if (aborted) begin
            push_slot(B_BUSY | B_CLR, 0, 0, cur_b);
        end else if (kind != 2'd2) begin
            for (int k = 0; k < crc_len; k++) push_slot(B_BUSY, 1, 0, cur_b);
            push_slot(B_BUSY, 0, 0, cur_b);
        end
        for (int k = 0; k < int'(EOP_LEN); k++)
            push_slot(B_BUSY | B_EOP | ((k == int'(EOP_LEN) - 1) ? B_DONE : 12'h0), 0,
                      k != int'(EOP_LEN) - 1, cur_b);
        push_slot(12'h0, 0, 0, cur_b);
    endtask

    // Drives one packet from cycle 0 and compares every following cycle to the schedule.
    task automatic run_pkt(input string name, input logic [1:0] kind, input logic [3:0] p,
                           input logic [6:0] a, input logic [3:0] e, input int rst_at,
                           output int done_cyc);
        cyc_t c;
        build(kind, p, a, e);
        done_cyc = -1;
        @(posedge clk);
        #1;
        start = 1'b1; pkt_kind = kind; pid = p; addr = a; endp = e;
        stall = 1'b0; crc_sending = 1'b0;
        byte_in = pbytes[0]; byte_valid = (pund != 0); byte_last = (pn == 1);
        #4 check_val({name, "_c0"}, 32'(outs()), 32'(12'h0));
        for (int i = 0; i < sched.size(); i++) begin
            c = sched[i];
            @(posedge clk);
            #1;
            // junk on request/field inputs while busy must be ignored
            start    = (i < sched.size() - 1) ? 1'($urandom) : 1'b0;
            pkt_kind = 2'($urandom);
            pid = 4'($urandom); addr = 7'($urandom); endp = 4'($urandom);
            stall = c.stl;
            crc_sending = c.sending;
            byte_in    = (c.bidx < 8) ? pbytes[c.bidx] : 8'($urandom);
            byte_valid = (c.bidx != pund) && (c.bidx < pn);
            byte_last  = (c.bidx == pn - 1);
            if (i == rst_at) begin
                #1 rst = 1'b1;
                #1 check_val($sformatf("%s_rst[%0d]", name, i), 32'(outs()), 32'(12'h0));
                #2 rst = 1'b0;
                start = 1'b0;
                return;
            end
            #4 check_val($sformatf("%s[%0d]", name, i), 32'(outs()), 32'(c.out));
            if (done && done_cyc < 0) done_cyc = i + 1;
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        int dc;
        logic [1:0] k;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 check_val("reset", 32'(outs()), 32'(12'h0));
        rst = 1'b0;

        pn = 0; pund = -1;
        run_pkt("token", 2'd0, 4'b1001, 7'h3A, 4'h1, -1, dc);
        check_val("token_done", dc, 36);

        pbytes[0] = 8'hA5; pbytes[1] = 8'h01; pn = 2; pund = -1;
        run_pkt("data2", 2'd1, 4'b0011, 7'h00, 4'h0, -1, dc);
        check_val("data2_done", dc, 52);

        pn = 0;
        run_pkt("hs", 2'd2, 4'b0010, 7'h00, 4'h0, -1, dc);
        check_val("hs_done", dc, 19);

        pn = 2; pund = -1;
        stall_plan[20] = 5; stall_plan[49] = 2;
        run_pkt("stall", 2'd1, 4'b0011, 7'h00, 4'h0, -1, dc);
        check_val("stall_done", dc, 59);
        stall_plan.delete();

        pbytes[2] = 8'h5C; pn = 3; pund = 1;
        run_pkt("under", 2'd1, 4'b1011, 7'h00, 4'h0, -1, dc);
        check_val("under_done", dc, 28);

        // reserved kind must not start a packet
        @(posedge clk);
        #1 start = 1'b1; pkt_kind = 2'd3;
        @(posedge clk);
        #1 start = 1'b0;
        #4 check_val("reserved", 32'(outs()), 32'(12'h0));

        pn = 0; pund = -1;
        run_pkt("rstmid", 2'd0, 4'b1001, 7'h3A, 4'h1, 11, dc);
        run_pkt("postrst", 2'd0, 4'b1001, 7'h3A, 4'h1, -1, dc);
        check_val("postrst_done", dc, 36);

        for (int t = 0; t < 25; t++) begin
            k = 2'($urandom_range(0, 2));
            pn = $urandom_range(1, 4);
            pund = -1;
            if (k == 2'd1 && pn > 1 && $urandom_range(0, 3) == 0) pund = $urandom_range(1, pn - 1);
            for (int j = 0; j < 8; j++) pbytes[j] = 8'($urandom);
            stall_plan.delete();
            for (int s = 0; s < 3; s++) stall_plan[$urandom_range(0, 60)] = $urandom_range(1, 4);
            run_pkt($sformatf("rnd%0d", t), k, 4'($urandom), 7'($urandom), 4'($urandom), -1, dc);
        end
        stall_plan.delete();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
